// File: rtl/ldst_pkg.sv
// Shared types and default constants for the ld/ldi/st control sequencer.
package ldst_pkg;

    localparam int unsigned OPC_W_DEF = 5;

    localparam logic [OPC_W_DEF-1:0] DEF_OP_LD   = 5'b00000;
    localparam logic [OPC_W_DEF-1:0] DEF_OP_LDI  = 5'b00001;
    localparam logic [OPC_W_DEF-1:0] DEF_OP_ST   = 5'b00010;
    localparam logic [OPC_W_DEF-1:0] DEF_ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE, ERR
    } state_t;

    typedef enum logic [1:0] {
        K_LD, K_LDI, K_ST
    } kind_t;

    // One-hot datapath/memory strobes plus status flags, registered together
    typedef struct packed {
        logic pc_out;
        logic inc_pc;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic y_in;
        logic zlow_in;
        logic zlow_out;
        logic busy;
        logic done;
        logic err;
    } strobe_t;

    // States that stall on mem_ready and are guarded by the timeout counter
    function automatic logic is_wait(state_t s, kind_t k);
        return (s == T1) || (s == T6 && k == K_LD) || (s == T7 && k == K_ST);
    endfunction

endpackage

// File: rtl/ldst_wait_timer.sv
// Loadable down-counter; expired is high once TMO wait cycles have been spent.
module ldst_wait_timer #(
    parameter int unsigned TMO = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int unsigned CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

    logic [CNT_W-1:0] cnt;

    // Loaded with TMO-1 so the TMO-th low cycle sees zero
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(TMO - 1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ldst_sequencer.sv
// Moore control sequencer for ld/ldi/st with memory wait states and error state.
// Optional LDST_CYCCNT_EN adds cyc_cnt: busy cycles of the last completed instruction.
module ldst_sequencer
    import ldst_pkg::*;
#(
    parameter int unsigned      IR_W    = 32,
    parameter int unsigned      OPC_W   = OPC_W_DEF,
    parameter logic [OPC_W-1:0] OP_LD   = OPC_W'(DEF_OP_LD),
    parameter logic [OPC_W-1:0] OP_LDI  = OPC_W'(DEF_OP_LDI),
    parameter logic [OPC_W-1:0] OP_ST   = OPC_W'(DEF_OP_ST),
    parameter logic [OPC_W-1:0] ALU_ADD = OPC_W'(DEF_ALU_ADD),
    parameter int unsigned      MEM_TMO = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [IR_W-1:0]  ir,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             IncPC,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Read,
    output logic             Write,
    output logic             Gra,
    output logic             Grb,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic             Yin,
    output logic             ZLowIn,
    output logic             Zlowout,
    output logic [OPC_W-1:0] opcode,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef LDST_CYCCNT_EN
    ,
    output logic [15:0]      cyc_cnt
`endif
);

    state_t           state, state_nxt;
    kind_t            kind, kind_nxt;
    strobe_t          strb;
    logic [OPC_W-1:0] alu_op;
    logic [OPC_W-1:0] opc;
    logic             tmr_load, tmr_dec, tmr_exp;
    logic             unused_ir;

    assign opc       = ir[IR_W-1 -: OPC_W];
    assign unused_ir = ^ir[IR_W-OPC_W-1:0];

    // Strobe decode for a state; first marks the entry cycle of that state
    function automatic strobe_t decode(state_t s, kind_t k, logic first);
        strobe_t r;
        r      = '0;
        r.busy = (s != IDLE);
        case (s)
            T0: begin
                r.pc_out  = 1'b1;
                r.mar_in  = 1'b1;
                r.inc_pc  = 1'b1;
                r.zlow_in = 1'b1;
            end
            T1: begin
                r.zlow_out = 1'b1;
                r.pc_in    = first;
                r.read     = 1'b1;
                r.mdr_in   = 1'b1;
            end
            T2: begin
                r.mdr_out = 1'b1;
                r.ir_in   = 1'b1;
            end
            T3: begin
                r.grb    = 1'b1;
                r.ba_out = 1'b1;
                r.y_in   = 1'b1;
            end
            T4: begin
                r.c_out   = 1'b1;
                r.zlow_in = 1'b1;
            end
            T5: begin
                r.zlow_out = 1'b1;
                if (k == K_LDI) begin
                    r.gra  = 1'b1;
                    r.r_in = 1'b1;
                end else begin
                    r.mar_in = 1'b1;
                end
            end
            T6: begin
                r.mdr_in = 1'b1;
                if (k == K_ST) begin
                    r.gra   = 1'b1;
                    r.r_out = 1'b1;
                end else begin
                    r.read = 1'b1;
                end
            end
            T7: begin
                if (k == K_ST) begin
                    r.write = 1'b1;
                end else begin
                    r.mdr_out = 1'b1;
                    r.gra     = 1'b1;
                    r.r_in    = 1'b1;
                end
            end
            DONE:    r.done = 1'b1;
            ERR:     r.err  = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    // Next-state and opcode classification
    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        case (state)
            IDLE: if (start) state_nxt = T0;
            T0:   state_nxt = T1;
            T1: begin
                if (mem_ready)    state_nxt = T2;
                else if (tmr_exp) state_nxt = ERR;
            end
            T2: state_nxt = T3;
            T3: begin
                if (opc == OP_LD) begin
                    kind_nxt  = K_LD;
                    state_nxt = T4;
                end else if (opc == OP_LDI) begin
                    kind_nxt  = K_LDI;
                    state_nxt = T4;
                end else if (opc == OP_ST) begin
                    kind_nxt  = K_ST;
                    state_nxt = T4;
                end else begin
                    state_nxt = ERR;
                end
            end
            T4: state_nxt = T5;
            T5: state_nxt = (kind == K_LDI) ? DONE : T6;
            T6: begin
                if (kind == K_ST || mem_ready) state_nxt = T7;
                else if (tmr_exp)              state_nxt = ERR;
            end
            T7: begin
                if (kind != K_ST || mem_ready) state_nxt = DONE;
                else if (tmr_exp)              state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     if (start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign tmr_load = is_wait(state_nxt, kind_nxt) && (state_nxt != state);
    assign tmr_dec  = is_wait(state, kind) && !mem_ready;

    ldst_wait_timer #(.TMO(MEM_TMO)) u_timer (
        .clock   (clock),
        .clear   (clear),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .expired (tmr_exp)
    );

    // Outputs registered as the decode of the state being entered
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            kind   <= K_LD;
            strb   <= '0;
            alu_op <= '0;
        end else begin
            state  <= state_nxt;
            kind   <= kind_nxt;
            strb   <= decode(state_nxt, kind_nxt, state_nxt != state);
            alu_op <= (state_nxt == T4) ? ALU_ADD : '0;
        end
    end

    assign PCout   = strb.pc_out;
    assign IncPC   = strb.inc_pc;
    assign PCin    = strb.pc_in;
    assign MARin   = strb.mar_in;
    assign MDRin   = strb.mdr_in;
    assign MDRout  = strb.mdr_out;
    assign IRin    = strb.ir_in;
    assign Read    = strb.read;
    assign Write   = strb.write;
    assign Gra     = strb.gra;
    assign Grb     = strb.grb;
    assign Rin     = strb.r_in;
    assign Rout    = strb.r_out;
    assign BAout   = strb.ba_out;
    assign Cout    = strb.c_out;
    assign Yin     = strb.y_in;
    assign ZLowIn  = strb.zlow_in;
    assign Zlowout = strb.zlow_out;
    assign busy    = strb.busy;
    assign done    = strb.done;
    assign err     = strb.err;
    assign opcode  = alu_op;

`ifdef LDST_CYCCNT_EN
    logic [15:0] run_cnt;

    // Running busy-cycle count, published only when an instruction completes
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            run_cnt <= '0;
            cyc_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                run_cnt <= '0;
            end else if (state != IDLE && state != ERR && run_cnt != 16'hFFFF) begin
                run_cnt <= run_cnt + 16'd1;
            end
            if (state == DONE) begin
                cyc_cnt <= (run_cnt == 16'hFFFF) ? 16'hFFFF : run_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ldst_sequencer.md
Name: ldst_sequencer

Overview:
- Hardwired control sequencer for memory-reference instructions (ld, ldi, st) on the DataPath.
- Replaces hand-driven T0..T7 strobe sequences with a Moore FSM that decodes the opcode in IR and drives the one-hot register-transfer strobes.
- Adds a variable-latency memory handshake, configurable opcodes and timeout, and error reporting for illegal opcodes and memory timeouts.

Parameters:
- IR_W, 32, instruction width; opcode is ir[IR_W-1 -: OPC_W].
- OPC_W, 5, opcode/ALU-op width.
- OP_LD, 5'b00000, load opcode.
- OP_LDI, 5'b00001, load-immediate opcode.
- OP_ST, 5'b00010, store opcode.
- ALU_ADD, 5'b00011, ALU op driven during address computation.
- MEM_TMO, 16, maximum wait cycles for mem_ready before error (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- start  in  1  begin one instruction; sampled only in IDLE.
- ir  in  IR_W  instruction register contents; valid from T3 onward.
- mem_ready  in  1  memory access complete; sampled in wait states.
- PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin  out  1 each  datapath strobes.
- Read, Write  out  1 each  memory strobes.
- Gra, Grb, Rin, Rout, BAout, Cout, Yin, ZLowIn, Zlowout  out  1 each  register-select and bus strobes.
- opcode  out  OPC_W  ALU operation; ALU_ADD in T4, otherwise 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  high in ERR state.

Behaviour:
- Reset: state=IDLE, every output 0, timeout counter 0. Reset takes effect immediately from any state, including mid-access.
- Outputs are a pure decode of the state register (Moore) and are stable for the whole cycle.
- States and asserted strobes:
  - IDLE: none. Go to T0 when start=1.
  - T0: PCout, MARin, IncPC, ZLowIn. Go to T1.
  - T1: Zlowout, PCin, Read, MDRin. Wait state. PCin is asserted only in the first cycle of T1, so PC is not incremented twice.
  - T2: MDRout, IRin. Go to T3.
  - T3: Grb, BAout, Yin. If the opcode is not OP_LD, OP_LDI or OP_ST, go to ERR.
  - T4: Cout, ZLowIn, opcode=ALU_ADD. Go to T5.
  - T5:
    - ldi: Zlowout, Gra, Rin; then DONE.
    - ld/st: Zlowout, MARin; then T6.
  - T6:
    - ld: Read, MDRin (wait state).
    - st: Gra, Rout, MDRin with the MDR bus path (single cycle).
  - T7:
    - ld: MDRout, Gra, Rin (single cycle).
    - st: Write (wait state).
  - DONE: done=1, busy=1. Go to IDLE.
  - ERR: err=1, no strobes. Go to IDLE when start=1; that start is consumed and does not launch an instruction.
- Wait-state rules (T1, ld T6, st T7):
  - Strobes are held while mem_ready=0.
  - The state advances at the edge where mem_ready=1; mem_ready high in the first cycle gives a 1-cycle step.
  - The timeout counter clears on entry to each wait state. If MEM_TMO cycles elapse with mem_ready low, go to ERR.
- start while busy: ignored. start and mem_ready in the same cycle: each acts only in its own state.
- Step totals with zero wait:
  - ld: 8 steps, done in the 9th cycle after start is sampled.
  - st: 8 steps.
  - ldi: 6 steps.

Optional Feature:
- Macro: LDST_CYCCNT_EN.
- Defined: adds output cyc_cnt[15:0], the total busy cycles of the last completed instruction.
  - Counter clears on start acceptance and saturates at 16'hFFFF.
  - Value latches at DONE and holds until the next DONE; ERR does not update it.
  - Reset value 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package ldst_pkg: state enum (IDLE, T0..T7, DONE, ERR), default opcode constants, ALU_ADD.
- Sub-module ldst_wait_timer: loadable down-counter producing the timeout flag; one instance, shared by all wait states.

Test Plan:
- ld, ir=32'h00880000, mem_ready tied 1 -> strobe sets match T0..T7 exactly; done pulses 9 cycles after start; Write never asserted.
- ldi, opcode 00001 -> Read asserted in T1 only; Gra+Rin in T5; done 7 cycles after start; MARin is not asserted after T0.
- st, opcode 00010, mem_ready low 3 cycles in T7 -> Write held 4 cycles; Rin never asserted; Rout+Gra in T6.
- mem_ready low 16 cycles in T1 (MEM_TMO=16) -> ERR entered; err=1; all strobes 0; the next start returns to IDLE with no T0.
- Illegal opcode 5'b11111 -> ERR after T3; T4 opcode output is never ALU_ADD.
- clear driven low mid-T6 of ld -> all outputs 0 asynchronously; a fresh start after clear releases runs a full ld.
